mini_alu_mc: RTL and testbench

Parametrised two-stage (fetch / execute) mini-ALU core with an internal dual-read, single-write data RAM, an external instruction ROM port, a registered LED output and a multi-cycle iterative multiplier. It adds forwarding, branch squash, shifts, BEQ and HALT, with configurable data, address and IP widths. It sits between the instruction ROM and the board LEDs as the top-level datapath of the test designs.

---
 rtl/mini_alu_mc_pkg.sv | 32 +++
 rtl/mini_alu_mc_if.sv | 34 +++
 rtl/mini_alu_mc_mul_iter.sv | 76 +++++++
 rtl/mini_alu_mc.sv | 172 +++++++++++++++++
 tb/tb_mini_alu_mc.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mini_alu_mc_pkg.sv
// mini_alu_mc shared definitions: opcodes, field widths
// and the instruction-width derivation used by all ALU variants.
package mini_alu_mc_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'h0,
    OP_LED  = 4'h1,
    OP_BLE  = 4'h2,
    OP_STO  = 4'h3,
    OP_ADD  = 4'h4,
    OP_JMP  = 4'h5,
    OP_SUB  = 4'h6,
    OP_IMUL = 4'h7,
    OP_SHL  = 4'h8,
    OP_SHR  = 4'h9,
    OP_BEQ  = 4'hA,
    OP_HALT = 4'hF
  } op_e;

  typedef enum logic {
    MUL_IDLE,
    MUL_RUN
  } mul_st_e;

  // [op][dst][src1][src0]
  function automatic int instr_w(input int addr_w);
    return OP_W + 3 * addr_w;
  endfunction

endpackage

// File: rtl/mini_alu_mc_if.sv
// mini_alu_mc external bus: instruction ROM port, fetch address,
// LED value and status flags.
interface mini_alu_mc_if #(
  parameter int ADDR_W = 8,
  parameter int IP_W   = 16,
  parameter int LED_W  = 8
);
  import mini_alu_mc_pkg::*;

  localparam int INSTR_W = instr_w(ADDR_W);

  logic [INSTR_W-1:0] iInstruction;
  logic [IP_W-1:0]    oIP;
  logic [LED_W-1:0]   oLed;
  logic               oBusy;
  logic               oHalt;

  modport master (
    input  iInstruction,
    output oIP,
    output oLed,
    output oBusy,
    output oHalt
  );

  modport slave (
    output iInstruction,
    input  oIP,
    input  oLed,
    input  oBusy,
    input  oHalt
  );

endinterface

// File: rtl/mini_alu_mc_mul_iter.sv
// mini_alu_mc iterative multiplier: unsigned shift-add,
// one multiplier bit per cycle, DATA_W cycles per product.
module mini_alu_mc_mul_iter
  import mini_alu_mc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  mul_st_e           st_q, st_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mc_q, mc_d;
  logic [DATA_W-1:0] mp_q, mp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              run;
  logic [DATA_W-1:0] mc, mp, sum;
  logic [CNT_W-1:0]  cnt;

  // Bit 0 is consumed straight from the operands in the start cycle,
  // so the last bit lands in cycle DATA_W-1 with done asserted.
  always_comb begin
    st_d  = st_q;
    acc_d = acc_q;
    mc_d  = mc_q;
    mp_d  = mp_q;
    cnt_d = cnt_q;
    run   = (st_q == MUL_RUN);
    mc    = run ? mc_q : a_i;
    mp    = run ? mp_q : b_i;
    cnt   = run ? cnt_q : '0;
    sum   = (run ? acc_q : '0) + (mp[0] ? mc : '0);
    busy_o    = run || start_i;
    done_o    = busy_o && (cnt == LAST);
    product_o = sum;
    if (busy_o) begin
      if (done_o) begin
        st_d = MUL_IDLE;
      end else begin
        st_d  = MUL_RUN;
        acc_d = sum;
        mc_d  = mc << 1;
        mp_d  = mp >> 1;
        cnt_d = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      st_q  <= MUL_IDLE;
      acc_q <= '0;
      mc_q  <= '0;
      mp_q  <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      acc_q <= acc_d;
      mc_q  <= mc_d;
      mp_q  <= mp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mini_alu_mc.sv
// mini_alu_mc: two-stage fetch/execute mini-ALU core with
// forwarding data RAM, branch squash, HALT and iterative IMUL.
module mini_alu_mc
  import mini_alu_mc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int IP_W   = 16,
  parameter int LED_W  = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  mini_alu_mc_if.master bus
);

  localparam int INSTR_W = instr_w(ADDR_W);
  localparam int IMM_W   = 2 * ADDR_W;

  logic [OP_W-1:0]   f_op;
  logic [ADDR_W-1:0] f_dst, f_s1, f_s0;
  logic [IMM_W-1:0]  f_imm;

  logic [OP_W-1:0]   ex_op_q, ex_op_d;
  logic [ADDR_W-1:0] ex_dst_q, ex_dst_d;
  logic [IMM_W-1:0]  ex_imm_q, ex_imm_d;
  logic [DATA_W-1:0] ex_a_q, ex_a_d;
  logic [DATA_W-1:0] ex_b_q, ex_b_d;
  logic [IP_W-1:0]   ip_q, ip_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              halt_q, halt_d;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              take, is_halt, led_we;
  logic              ex_imul, stall;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [IP_W-1:0]   target;
  logic              mul_busy, mul_done;
  logic [DATA_W-1:0] mul_prod;

  assign f_op  = bus.iInstruction[INSTR_W-1 -: OP_W];
  assign f_dst = bus.iInstruction[3*ADDR_W-1 -: ADDR_W];
  assign f_imm = bus.iInstruction[IMM_W-1:0];
  assign f_s1  = f_imm[IMM_W-1 -: ADDR_W];
  assign f_s0  = f_imm[ADDR_W-1:0];

  assign ex_imul = (ex_op_q == OP_IMUL);
  assign target  = IP_W'(ex_dst_q);
  assign stall   = mul_busy && !mul_done;

  mini_alu_mc_mul_iter #(
    .DATA_W (DATA_W)
  ) u_mul (
    .Clock     (Clock),
    .Reset     (Reset),
    .start_i   (ex_imul),
    .a_i       (ex_a_q),
    .b_i       (ex_b_q),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_comb begin
    we      = 1'b0;
    wdata   = '0;
    take    = 1'b0;
    is_halt = 1'b0;
    led_we  = 1'b0;
    unique case (1'b1)
      ex_op_q == OP_ADD: begin
        we    = 1'b1;
        wdata = ex_a_q + ex_b_q;
      end
      ex_op_q == OP_SUB: begin
        we    = 1'b1;
        wdata = ex_a_q - ex_b_q;
      end
      ex_op_q == OP_STO: begin
        we    = 1'b1;
        wdata = DATA_W'(ex_imm_q);
      end
      ex_op_q == OP_SHL: begin
        we    = 1'b1;
        wdata = ex_a_q << ex_b_q;
      end
      ex_op_q == OP_SHR: begin
        we    = 1'b1;
        wdata = ex_a_q >> ex_b_q;
      end
      ex_op_q == OP_IMUL: begin
        we    = mul_done;
        wdata = mul_prod;
      end
      ex_op_q == OP_LED:  led_we  = 1'b1;
      ex_op_q == OP_JMP:  take    = 1'b1;
      ex_op_q == OP_BLE:  take    = (ex_a_q <= ex_b_q);
      ex_op_q == OP_BEQ:  take    = (ex_a_q == ex_b_q);
      ex_op_q == OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  // A write landing this edge must be seen by the operand capture.
  assign rd_a = (we && ex_dst_q == f_s1) ? wdata : mem_q[f_s1];
  assign rd_b = (we && ex_dst_q == f_s0) ? wdata : mem_q[f_s0];

  always_comb begin
    ip_d     = ip_q;
    led_d    = led_q;
    halt_d   = halt_q;
    ex_op_d  = ex_op_q;
    ex_dst_d = ex_dst_q;
    ex_imm_d = ex_imm_q;
    ex_a_d   = ex_a_q;
    ex_b_d   = ex_b_q;
    if (led_we) led_d = ex_a_q[LED_W-1:0];
    if (!halt_q && !stall) begin
      if (take) begin
        ip_d    = target;
        ex_op_d = OP_NOP;
      end else begin
        ip_d = ip_q + 1'b1;
        if (is_halt) begin
          halt_d  = 1'b1;
          ex_op_d = OP_NOP;
        end else begin
          ex_op_d  = f_op;
          ex_dst_d = f_dst;
          ex_imm_d = f_imm;
          ex_a_d   = rd_a;
          ex_b_d   = rd_b;
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ip_q     <= '0;
      led_q    <= '0;
      halt_q   <= 1'b0;
      ex_op_q  <= OP_NOP;
      ex_dst_q <= '0;
      ex_imm_q <= '0;
      ex_a_q   <= '0;
      ex_b_q   <= '0;
    end else begin
      ip_q     <= ip_d;
      led_q    <= led_d;
      halt_q   <= halt_d;
      ex_op_q  <= ex_op_d;
      ex_dst_q <= ex_dst_d;
      ex_imm_q <= ex_imm_d;
      ex_a_q   <= ex_a_d;
      ex_b_q   <= ex_b_d;
    end
  end

  // Execute holds NOP throughout reset, so no write can slip in.
  always_ff @(posedge Clock) begin
    if (we) mem_q[ex_dst_q] <= wdata;
  end

  assign bus.oIP   = ip_q;
  assign bus.oLed  = led_q;
  assign bus.oBusy = mul_busy;
  assign bus.oHalt = halt_q;

endmodule

// File: tb/tb_mini_alu_mc.sv
// tb_mini_alu_mc: cycle-by-cycle check of oIP/oLed/oBusy/oHalt
// against an instruction-level model with timing rules.
module tb_mini_alu_mc;
  import mini_alu_mc_pkg::*;

  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int IPW  = 16;
  localparam int LW   = 8;
  localparam int IW   = 4 + 3 * AW;
  localparam int MAXC = 4096;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  logic [IW-1:0] rom  [256];
  logic [DW-1:0] mram [256];
  logic [31:0]   e_ip [MAXC];
  logic [31:0]   e_led [MAXC];
  logic [31:0]   e_busy [MAXC];
  logic [31:0]   e_halt [MAXC];

  int nvec = 0;
  int nbad = 0;

  always #5 Clock = ~Clock;

  mini_alu_mc_if #(.ADDR_W(AW), .IP_W(IPW), .LED_W(LW)) bus ();

  mini_alu_mc #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .IP_W   (IPW),
    .LED_W  (LW)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always_comb bus.iInstruction = rom[bus.oIP[7:0]];

  function automatic logic [IW-1:0] ins(input logic [3:0] op,
                                        input int d, input int s1,
                                        input int s0);
    return {op, 8'(d), 8'(s1), 8'(s0)};
  endfunction

  function automatic logic [IW-1:0] sto(input int d, input int imm);
    return {OP_STO, 8'(d), 16'(imm)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic put(input int c, input int ip, input logic [7:0] led,
                     input bit busy, input bit halt);
    if (c >= 0 && c < MAXC) begin
      e_ip[c]   = 32'(ip & 32'hFFFF);
      e_led[c]  = 32'(led);
      e_busy[c] = 32'(busy);
      e_halt[c] = 32'(halt);
    end
  endtask

  // Sequential ISA interpreter; cycle n follows edge n after reset.
  // Effects landing after edge 'cut' are dropped (reset hits first).
  task automatic model(input int cut, output int hc);
    int t, p, d;
    logic [7:0]  led, dst, s1, s0;
    logic [3:0]  op;
    logic [15:0] a, b, res;
    logic [31:0] prod;
    bit wr, tk;
    hc  = -1;
    led = 8'h0;
    p   = 0;
    t   = 1;
    put(0, 0, 8'h0, 1'b0, 1'b0);
    while (t < MAXC) begin
      {op, dst, s1, s0} = rom[p & 255];
      a  = mram[s1];
      b  = mram[s0];
      d  = (op == OP_IMUL) ? DW : 1;
      for (int k = 0; k < d; k++) put(t + k, p + 1, led, op == OP_IMUL, 1'b0);
      wr  = 1'b0;
      tk  = 1'b0;
      res = 16'h0;
      case (op)
        OP_ADD:  begin wr = 1'b1; res = a + b; end
        OP_SUB:  begin wr = 1'b1; res = a - b; end
        OP_STO:  begin wr = 1'b1; res = {s1, s0}; end
        OP_SHL:  begin wr = 1'b1; res = (b >= 16) ? 16'h0 : a << b; end
        OP_SHR:  begin wr = 1'b1; res = (b >= 16) ? 16'h0 : a >> b; end
        OP_IMUL: begin
          wr   = 1'b1;
          prod = 32'(a) * 32'(b);
          res  = prod[15:0];
        end
        OP_JMP:  tk = 1'b1;
        OP_BLE:  tk = (a <= b);
        OP_BEQ:  tk = (a == b);
        default: ;
      endcase
      if (t + d > cut) break;
      if (wr) mram[dst] = res;
      if (op == OP_LED) led = a[7:0];
      t += d;
      if (op == OP_HALT) begin
        hc = t;
        for (int k = t; k < MAXC; k++) put(k, p + 2, led, 1'b0, 1'b1);
        break;
      end
      if (tk) begin
        put(t, int'(dst), led, 1'b0, 1'b0);
        t++;
        p = int'(dst);
      end else begin
        p = p + 1;
      end
    end
  endtask

  task automatic go(input int cut, input string nm);
    int hc, n;
    model(cut, hc);
    if (cut < MAXC) n = cut + 1;
    else if (hc >= 0) n = hc + 100;
    else n = MAXC;
    if (n > MAXC) n = MAXC;
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    for (int c = 0; c < n; c++) begin
      chk($sformatf("%s.ip@%0d", nm, c), 32'(bus.oIP), e_ip[c]);
      chk($sformatf("%s.led@%0d", nm, c), 32'(bus.oLed), e_led[c]);
      chk($sformatf("%s.busy@%0d", nm, c), 32'(bus.oBusy), e_busy[c]);
      chk($sformatf("%s.halt@%0d", nm, c), 32'(bus.oHalt), e_halt[c]);
      if (c < n - 1) begin
        @(posedge Clock);
        #1;
      end
    end
  endtask

  task automatic clr_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic gen_rand();
    int L, sel, tg;
    logic [3:0] opl [14];
    logic [3:0] op;
    int s1, s0;
    opl = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
            4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE};
    clr_rom();
    L = 8 + int'($urandom_range(16, 40));
    for (int i = 0; i < 8; i++)
      rom[i] = sto(i, (i >= 6) ? int'($urandom_range(0, 20))
                               : int'($urandom & 32'hFFFF));
    for (int a = 8; a < L - 1; a++) begin
      sel = int'($urandom_range(0, 13));
      op  = opl[sel];
      s1  = int'($urandom_range(0, 7));
      s0  = int'($urandom_range(0, 7));
      if (op == OP_STO) begin
        rom[a] = sto(int'($urandom_range(0, 7)), int'($urandom & 32'hFFFF));
      end else if (op == OP_JMP || op == OP_BLE || op == OP_BEQ) begin
        tg = int'($urandom_range(a + 1, L - 1));
        if (op == OP_BEQ && $urandom_range(0, 1) == 1) s0 = s1;
        rom[a] = ins(op, tg, s1, s0);
      end else begin
        rom[a] = ins(op, int'($urandom_range(0, 7)), s1, s0);
      end
    end
    rom[L-1] = ins(OP_HALT, 0, 0, 0);
  endtask

  initial begin
    clr_rom();
    rom[0]  = sto(1, 5);
    rom[1]  = sto(2, 3);
    rom[2]  = ins(OP_ADD, 3, 1, 2);
    rom[3]  = ins(OP_LED, 0, 3, 0);
    rom[4]  = ins(OP_SUB, 4, 2, 1);
    rom[5]  = ins(OP_LED, 0, 4, 0);
    rom[6]  = sto(5, 20);
    rom[7]  = ins(OP_SHL, 6, 1, 5);
    rom[8]  = ins(OP_LED, 0, 6, 0);
    rom[9]  = sto(7, 16'h00FF);
    rom[10] = sto(8, 16'h0101);
    rom[11] = ins(OP_IMUL, 9, 7, 8);
    rom[12] = ins(OP_LED, 0, 9, 0);
    rom[13] = sto(10, 2);
    rom[14] = ins(OP_BLE, 8'h10, 10, 1);
    rom[15] = ins(OP_LED, 0, 3, 0);
    rom[16] = ins(OP_BEQ, 8'h20, 1, 2);
    rom[17] = ins(OP_LED, 0, 4, 0);
    rom[18] = ins(OP_HALT, 0, 0, 0);
    rom[19] = ins(OP_LED, 0, 3, 0);
    go(MAXC, "plan");

    clr_rom();
    rom[0] = sto(1, 16'h002A);
    rom[1] = ins(OP_LED, 0, 1, 0);
    rom[4] = ins(OP_HALT, 0, 0, 0);
    rom[5] = ins(OP_LED, 0, 3, 0);
    rom[6] = ins(OP_LED, 0, 3, 0);
    go(MAXC, "halt");

    clr_rom();
    rom[0] = sto(1, 7);
    rom[1] = sto(2, 9);
    rom[2] = sto(3, 16'h0055);
    rom[3] = ins(OP_IMUL, 3, 1, 2);
    rom[4] = ins(OP_LED, 0, 3, 0);
    rom[5] = ins(OP_HALT, 0, 0, 0);
    go(10, "mulrst");
    Reset = 1'b1;
    #1;
    chk("arst.ip", 32'(bus.oIP), 32'h0);
    chk("arst.led", 32'(bus.oLed), 32'h0);
    chk("arst.busy", 32'(bus.oBusy), 32'h0);
    chk("arst.halt", 32'(bus.oHalt), 32'h0);

    clr_rom();
    rom[0] = ins(OP_LED, 0, 3, 0);
    rom[1] = ins(OP_HALT, 0, 0, 0);
    go(MAXC, "nowr");

    for (int r = 0; r < 4; r++) begin
      gen_rand();
      go(MAXC, $sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
